// File: rtl/temp_pkg.sv
// Shared state encodings and default sizing for the ring-oscillator temperature controller.
`timescale 1ns/1ps
package temp_pkg;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_STARTUP_CYCLES = 1;
    localparam int unsigned DEF_WINDOW_CYCLES  = 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t STARTUP = 3'd1;
    localparam state_t MEASURE = 3'd2;
    localparam state_t STOP    = 3'd3;
    localparam state_t DONE    = 3'd4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/temp_counter.sv
// Oscillator-domain edge counter; cleared asynchronously while reset is high, wraps at 2^WIDTH.
`timescale 1ns/1ps
module temp_counter
    import temp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/temp_fsm.sv
// lfClk measurement sequencer: power oscillator, open counting window, stop, latch code.
// Optional TEMP_FSM_OSC_CHECK_EN adds a dead-oscillator detector and the oscErr output.
`timescale 1ns/1ps
module temp_fsm
    import temp_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES
) (
    input  logic             lfClk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clkOsc,
    input  logic [WIDTH-1:0] count,
    output logic             done,
    output logic             resetCount,
    output logic             pwrupOsc,
    output logic [WIDTH-1:0] cycles
`ifdef TEMP_FSM_OSC_CHECK_EN
    ,
    output logic             oscErr
`endif
);

    localparam int unsigned PHASE_W = $clog2(max_u(STARTUP_CYCLES, WINDOW_CYCLES)) + 1;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               start_q;
    logic [WIDTH-1:0]   cycles_d;
    logic               pwrup_d, reset_count_d, done_d;

`ifdef TEMP_FSM_OSC_CHECK_EN
    logic [1:0] osc_sync_q;
    logic       osc_prev_q;
    logic       osc_seen_q, osc_seen_d;
    logic       osc_err_d;
    logic       osc_edge_c;

    assign osc_edge_c = osc_sync_q[1] ^ osc_prev_q;

    // clkOsc is asynchronous to lfClk: two-flop synchronizer plus edge history
    always_ff @(posedge lfClk or negedge rst_n) begin
        if (!rst_n) begin
            osc_sync_q <= 2'b00;
            osc_prev_q <= 1'b0;
        end else begin
            osc_sync_q <= {osc_sync_q[0], clkOsc};
            osc_prev_q <= osc_sync_q[1];
        end
    end
`else
    logic unused_clk_osc;
    assign unused_clk_osc = clkOsc;
`endif

    // Next-state, phase and result logic
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cycles_d = cycles;
`ifdef TEMP_FSM_OSC_CHECK_EN
        osc_seen_d = osc_seen_q;
        osc_err_d  = oscErr;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_q) begin
                    state_d = STARTUP;
                    phase_d = '0;
`ifdef TEMP_FSM_OSC_CHECK_EN
                    osc_seen_d = 1'b0;
`endif
                end
            end
            STARTUP: begin
                if (phase_q == PHASE_W'(STARTUP_CYCLES - 1)) begin
                    state_d = MEASURE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
`ifdef TEMP_FSM_OSC_CHECK_EN
                if (osc_edge_c) osc_seen_d = 1'b1;
`endif
            end
            MEASURE: begin
                if (phase_q == PHASE_W'(WINDOW_CYCLES - 1)) begin
                    state_d = STOP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
`ifdef TEMP_FSM_OSC_CHECK_EN
                if (osc_edge_c) osc_seen_d = 1'b1;
`endif
            end
            STOP: begin
                // oscillator is already powered down here, so count is static
                state_d = DONE;
`ifdef TEMP_FSM_OSC_CHECK_EN
                osc_err_d = !osc_seen_q && (count == '0);
                cycles_d  = osc_err_d ? '1 : count;
`else
                cycles_d  = count;
`endif
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        pwrup_d       = (state_d == STARTUP) || (state_d == MEASURE);
        reset_count_d = !((state_d == MEASURE) || (state_d == STOP));
        done_d        = (state_d == DONE);
    end

    // State and registered outputs
    always_ff @(posedge lfClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            start_q    <= 1'b0;
            pwrupOsc   <= 1'b0;
            resetCount <= 1'b1;
            done       <= 1'b0;
            cycles     <= '0;
`ifdef TEMP_FSM_OSC_CHECK_EN
            osc_seen_q <= 1'b0;
            oscErr     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            start_q    <= start;
            pwrupOsc   <= pwrup_d;
            resetCount <= reset_count_d;
            done       <= done_d;
            cycles     <= cycles_d;
`ifdef TEMP_FSM_OSC_CHECK_EN
            osc_seen_q <= osc_seen_d;
            oscErr     <= osc_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_temp_fsm.sv
// Scoreboard bench for temp_fsm driving a behavioural ring oscillator into temp_counter.
`timescale 1ns/1ps
module tb_temp_fsm;
    import temp_pkg::*;

    localparam int unsigned WB = DEF_WIDTH;
    localparam int unsigned S  = DEF_STARTUP_CYCLES;
    localparam int unsigned WN = DEF_WINDOW_CYCLES;
    localparam real LF_PERIOD  = 30517.0;
    localparam int LAT         = int'(3 + S + WN);
    localparam int B2B         = int'(2 + S + WN);

    logic          lfClk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          clkOsc = 1'b0;
    logic [WB-1:0] count;
    logic          done, resetCount, pwrupOsc;
    logic [WB-1:0] cycles;
`ifdef TEMP_FSM_OSC_CHECK_EN
    logic          oscErr;
`endif

    real osc_half  = 500.0;
    bit  osc_stuck = 1'b0;

    typedef struct {
        int exp_edge;
        int lo;
        int tol;
        int err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic done_prev = 1'b0;
    int   pw_run = 0;
    int   pw_last = 0;

    temp_fsm #(.WIDTH(WB), .STARTUP_CYCLES(S), .WINDOW_CYCLES(WN)) u_dut (
        .lfClk(lfClk), .rst_n(rst_n), .start(start), .clkOsc(clkOsc), .count(count),
        .done(done), .resetCount(resetCount), .pwrupOsc(pwrupOsc), .cycles(cycles)
`ifdef TEMP_FSM_OSC_CHECK_EN
        , .oscErr(oscErr)
`endif
    );

    temp_counter #(.WIDTH(WB)) u_cnt (.clk(clkOsc), .reset(resetCount), .count(count));

    always #(LF_PERIOD / 2.0) lfClk = ~lfClk;

    always @(posedge lfClk) edge_cnt <= edge_cnt + 1;

    // Ring oscillator: runs only while powered, parks low when stopped
    initial forever begin
        wait (pwrupOsc && !osc_stuck);
        #(osc_half);
        clkOsc = pwrupOsc ? ~clkOsc : 1'b0;
    end

    initial begin
        #(LF_PERIOD * 3000.0);
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        checks++;
        if (obs < exp || obs > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d..%0d", tag, obs, exp, exp + tol);
        end
    endtask

    function automatic int exp_count(input real period);
        return int'($floor(LF_PERIOD * real'(WN) / period)) % (1 << WB);
    endfunction

    task automatic push_exp(input int edge_at, input int lo, input int tol, input int err);
        exp_t x;
        x.exp_edge = edge_at;
        x.lo = lo;
        x.tol = tol;
        x.err = err;
        sb.push_back(x);
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge lfClk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0, 0);
            sb.delete();
        end
    endtask

    task automatic do_meas(input int lo, input int tol, input int err);
        @(negedge lfClk);
        start = 1'b1;
        push_exp(edge_cnt + LAT, lo, tol, err);
        @(negedge lfClk);
        start = 1'b0;
        wait_sb(40);
    endtask

    // Output monitor: sampled on falling lfClk, pops the scoreboard on each done rise
    always @(negedge lfClk) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
            pw_run    <= 0;
        end else begin
            done_prev <= done;
            if (pwrupOsc) pw_run <= pw_run + 1;
            else if (pw_run != 0) begin
                pw_last <= pw_run;
                pw_run  <= 0;
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_latency", edge_cnt, mon_e.exp_edge, 0);
                    check("cycles", int'(cycles), mon_e.lo, mon_e.tol);
`ifdef TEMP_FSM_OSC_CHECK_EN
                    check("osc_err", int'(oscErr), mon_e.err, 0);
`endif
                end
            end
        end
    end

    int temps[5] = '{-40, 0, 40, 85, 125};
    int prev_cyc;
    int e0;

    initial begin
        #5 rst_n = 1'b0;
        #1;
        check("rst_done", int'(done), 0, 0);
        check("rst_cycles", int'(cycles), 0, 0);
        check("rst_pwrup", int'(pwrupOsc), 0, 0);
        check("rst_rescnt", int'(resetCount), 1, 0);
        repeat (2) @(negedge lfClk);
        rst_n = 1'b1;
        repeat (2) @(negedge lfClk);

        // Single measurement at 1 MHz
        osc_half = 500.0;
        do_meas(exp_count(1000.0), 1, 0);
        check("pwrup_periods", pw_last, int'(S + WN), 0);
        repeat (3) @(negedge lfClk);
        check("done_held", int'(done), 1, 0);
        check("pwrup_off_in_done", int'(pwrupOsc), 0, 0);

        // Temperature sweep: faster oscillator when hotter
        prev_cyc = -1;
        foreach (temps[i]) begin
            real p;
            p = 1400.0 - 3.0 * real'(temps[i] + 40);
            osc_half = p / 2.0;
            do_meas(exp_count(p), 1, 0);
            check("sweep_monotonic", (int'(cycles) > prev_cyc) ? 1 : 0, 1, 0);
            prev_cyc = int'(cycles);
        end

        // Counter wrap: 305 true edges reported modulo 256
        osc_half = 50.0;
        do_meas(exp_count(100.0), 1, 0);
        check("wrap_value", int'(cycles), 49, 1);

        // start toggled while measuring is ignored
        osc_half = 500.0;
        @(negedge lfClk);
        start = 1'b1;
        e0 = edge_cnt;
        push_exp(e0 + LAT, exp_count(1000.0), 1, 0);
        @(negedge lfClk);
        start = 1'b0;
        repeat (1 + S) @(negedge lfClk);
        check("in_measure_rescnt", int'(resetCount), 0, 0);
        start = 1'b1;
        @(negedge lfClk);
        start = 1'b0;
        wait_sb(40);
        repeat (6) @(negedge lfClk);
        check("toggle_done_held", int'(done), 1, 0);

        // start held high: back-to-back measurements, one-period done pulses
        @(negedge lfClk);
        start = 1'b1;
        e0 = edge_cnt;
        for (int k = 0; k < 3; k++) push_exp(e0 + LAT + k * B2B, exp_count(1000.0), 1, 0);
        while (edge_cnt < e0 + LAT + 2 * B2B - 1) begin
            @(negedge lfClk);
            if (edge_cnt == e0 + LAT + 1) check("b2b_done_pulse", int'(done), 0, 0);
        end
        start = 1'b0;
        wait_sb(40);
        repeat (6) @(negedge lfClk);

        // Reset asserted mid-measure
        start = 1'b1;
        @(negedge lfClk);
        start = 1'b0;
        repeat (1 + S) @(negedge lfClk);
        check("pre_rst_pwrup", int'(pwrupOsc), 1, 0);
        #100 rst_n = 1'b0;
        #1;
        check("mid_rst_done", int'(done), 0, 0);
        check("mid_rst_cycles", int'(cycles), 0, 0);
        check("mid_rst_pwrup", int'(pwrupOsc), 0, 0);
        check("mid_rst_rescnt", int'(resetCount), 1, 0);
        @(negedge lfClk);
        rst_n = 1'b1;
        repeat (8) @(negedge lfClk);
        check("post_rst_idle_pwrup", int'(pwrupOsc), 0, 0);

`ifdef TEMP_FSM_OSC_CHECK_EN
        // Dead oscillator reports all ones and raises oscErr; a live one clears it
        osc_stuck = 1'b1;
        do_meas((1 << WB) - 1, 0, 1);
        osc_stuck = 1'b0;
        do_meas(exp_count(1000.0), 1, 0);
`endif

        repeat (4) @(negedge lfClk);
        check("sb_empty", sb.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
